// File: rtl/stack_pkg.sv
// Shared types and per-operation stack-effect table for the stack operation sequencer.
package stack_pkg;

    localparam int unsigned DATA_W_DFLT = 8;
    localparam int unsigned ADDR_W_DFLT = 10;
    localparam int unsigned STACK_MAX   = (1 << ADDR_W_DFLT) - 1;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_NOT  = 3'd6,
        OP_DUP  = 3'd7
    } op_e;

    typedef logic [3:0] state_e;

    localparam state_e ST_IDLE     = 4'd0;
    localparam state_e ST_CHECK    = 4'd1;
    localparam state_e ST_RD_A     = 4'd2;
    localparam state_e ST_POP_A    = 4'd3;
    localparam state_e ST_RD_B     = 4'd4;
    localparam state_e ST_POP_B    = 4'd5;
    localparam state_e ST_WR_SETUP = 4'd6;
    localparam state_e ST_WR_PULSE = 4'd7;
    localparam state_e ST_DONE     = 4'd8;

    // reads: operands that must already be on the stack (DUP reads without popping)
    typedef struct packed {
        logic [1:0] reads;
        logic [1:0] pops;
        logic [1:0] pushes;
    } op_cnt_t;

    function automatic op_cnt_t op_counts(input op_e op);
        op_cnt_t c;
        unique case (op)
            OP_PUSH: c = '{reads: 2'd0, pops: 2'd0, pushes: 2'd1};
            OP_POP:  c = '{reads: 2'd1, pops: 2'd1, pushes: 2'd0};
            OP_NOT:  c = '{reads: 2'd1, pops: 2'd1, pushes: 2'd1};
            OP_DUP:  c = '{reads: 2'd1, pops: 2'd0, pushes: 2'd1};
            default: c = '{reads: 2'd2, pops: 2'd2, pushes: 2'd1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational datapath for the sequencer: b op a for binary ops, ~a for NOT, a otherwise.
module stack_alu
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  op_e               i_op,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = i_a;
        unique case (i_op)
            OP_ADD:  o_y = i_b + i_a;
            OP_SUB:  o_y = i_b - i_a;
            OP_AND:  o_y = i_b & i_a;
            OP_OR:   o_y = i_b | i_a;
            OP_NOT:  o_y = ~i_a;
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences one stack-machine operation at a time into single-cycle push/pop pulses
// for an edge-triggered stack, tracking depth to refuse underflow and overflow.
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT,
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_imm,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] depth
);

    localparam logic [ADDR_W:0] L_MAX = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_e            r_state;
    state_e            w_state_d;
    op_e               r_op;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_stk_din;
    logic [DATA_W-1:0] r_result;
    logic              r_ready;
    logic              r_push;
    logic              r_pop;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_depth;

    logic              w_accept;
    logic              w_chk_err;
    op_cnt_t           w_cnt;
    logic [ADDR_W:0]   w_depth_x;
    logic [ADDR_W:0]   w_after;
    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_wr_val;

    assign w_accept = op_valid && r_ready;

    assign w_cnt     = op_counts(r_op);
    assign w_depth_x = {1'b0, r_depth};
    assign w_after   = w_depth_x - (ADDR_W+1)'(w_cnt.pops) + (ADDR_W+1)'(w_cnt.pushes);
    assign w_chk_err = (w_depth_x < (ADDR_W+1)'(w_cnt.reads)) || (w_after > L_MAX);

    // DUP leaves RD_A straight for WR_SETUP, before r_a has been loaded
    assign w_alu_a  = (r_state == ST_RD_A) ? stk_dout : r_a;
    assign w_wr_val = (r_op == OP_PUSH) ? r_imm : w_alu_y;

    stack_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .i_a  (w_alu_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_y  (w_alu_y)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_chk_err)            w_state_d = ST_DONE;
                else if (r_op == OP_PUSH) w_state_d = ST_WR_SETUP;
                else                      w_state_d = ST_RD_A;
            end
            ST_RD_A: begin
                if (r_op == OP_DUP) w_state_d = ST_WR_SETUP;
                else                w_state_d = ST_POP_A;
            end
            ST_POP_A: begin
                if (r_op == OP_POP)      w_state_d = ST_DONE;
                else if (r_op == OP_NOT) w_state_d = ST_WR_SETUP;
                else                     w_state_d = ST_RD_B;
            end
            ST_RD_B:     w_state_d = ST_POP_B;
            ST_POP_B:    w_state_d = ST_WR_SETUP;
            ST_WR_SETUP: w_state_d = ST_WR_PULSE;
            ST_WR_PULSE: w_state_d = ST_DONE;
            ST_DONE:     w_state_d = ST_IDLE;
            default:     w_state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_PUSH;
            r_imm     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_stk_din <= '0;
            r_result  <= '0;
            r_ready   <= 1'b1;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_depth   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_op  <= op_e'(op_code);
                r_imm <= op_imm;
            end
            if (r_state == ST_RD_A) r_a <= stk_dout;
            if (r_state == ST_RD_B) r_b <= stk_dout;
            if (w_state_d == ST_WR_SETUP) r_stk_din <= w_wr_val;

            r_pop   <= (w_state_d == ST_POP_A) || (w_state_d == ST_POP_B);
            r_push  <= (w_state_d == ST_WR_PULSE);
            r_done  <= (w_state_d == ST_DONE);
            r_err   <= (r_state == ST_CHECK) && w_chk_err;
            r_ready <= (w_state_d == ST_IDLE);

            if (r_push)     r_depth <= r_depth + ADDR_W'(1);
            else if (r_pop) r_depth <= r_depth - ADDR_W'(1);

            if ((w_state_d == ST_DONE) && !((r_state == ST_CHECK) && w_chk_err)) begin
                r_result <= (r_op == OP_POP) ? r_a : r_stk_din;
            end
        end
    end

    assign op_ready = r_ready;
    assign stk_push = r_push;
    assign stk_pop  = r_pop;
    assign stk_din  = r_stk_din;
    assign result   = r_result;
    assign done     = r_done;
    assign err      = r_err;
    assign depth    = r_depth;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench: behavioural stack on the bus, queue-based reference model,
// directed vector table, full-stack and reset corner sequences, and random ops.
module tb_stack_op_sequencer;

    localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, NOT_ = 3'd6, DUP = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_imm;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic [7:0] result;
    logic       done;
    logic       err;
    logic [9:0] depth;

    always #5 clk = ~clk;

    stack_op_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_imm   (op_imm),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_din  (stk_din),
        .stk_dout (stk_dout),
        .result   (result),
        .done     (done),
        .err      (err),
        .depth    (depth)
    );

    // Edge-triggered stack; re-initialised together with rst_n.
    logic [7:0]  smem [0:1023];
    logic [10:0] sp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= '0;
        else if (stk_push) begin
            smem[sp[9:0]] <= stk_din;
            sp <= sp + 11'd1;
        end else if (stk_pop) sp <= sp - 11'd1;
    end
    assign stk_dout = (sp != 0) ? smem[sp - 11'd1] : 8'h00;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [7:0] m_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_result = 8'h00;
        @(negedge clk);
    endtask

    // Issue one op, check it against the reference model, return what the DUT reported.
    task automatic run_op(input logic [2:0] op, input logic [7:0] imm, input string tag,
                          output logic [7:0] g_res, output logic g_err, output int g_dep);
        logic       m_err;
        logic [7:0] a, b, wv;
        int         d, lat, e_push, e_pop, n_push, n_pop, cyc, waited, push_cyc, pop_cyc;
        logic       got, din_bad;
        logic [7:0] prev_din;
        d = mq.size();
        wv = 8'h00;
        unique case (op)
            PUSH:     m_err = (d == 1023);
            POP, NOT_: m_err = (d < 1);
            DUP:      m_err = (d < 1) || (d == 1023);
            default:  m_err = (d < 2);
        endcase
        if (m_err) begin
            lat = 2; e_push = 0; e_pop = 0;
        end else begin
            unique case (op)
                PUSH: begin wv = imm; mq.push_back(imm); m_result = imm;
                            lat = 4; e_push = 1; e_pop = 0; end
                POP:  begin a = mq.pop_back(); m_result = a;
                            lat = 4; e_push = 0; e_pop = 1; end
                DUP:  begin a = mq[$]; wv = a; mq.push_back(a); m_result = a;
                            lat = 5; e_push = 1; e_pop = 0; end
                NOT_: begin a = mq.pop_back(); wv = ~a; mq.push_back(wv); m_result = wv;
                            lat = 6; e_push = 1; e_pop = 1; end
                default: begin
                    a = mq.pop_back();
                    b = mq.pop_back();
                    unique case (op)
                        ADD:     wv = b + a;
                        SUB:     wv = b - a;
                        AND_:    wv = b & a;
                        default: wv = b | a;
                    endcase
                    mq.push_back(wv); m_result = wv;
                    lat = 8; e_push = 1; e_pop = 2;
                end
            endcase
        end

        waited = 0;
        while (!op_ready && waited < 20) begin @(negedge clk); waited++; end
        chk({tag, " ready"}, 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_code = op; op_imm = imm;
        @(posedge clk);
        cyc = 0; got = 1'b0; n_push = 0; n_pop = 0; din_bad = 1'b0;
        push_cyc = 0; pop_cyc = 0; prev_din = stk_din;
        g_res = 8'h00; g_err = 1'b0; g_dep = 0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) op_valid = 1'b0;
            if (stk_push) begin
                n_push++;
                if (push_cyc == 0) push_cyc = cyc;
                if (stk_din !== prev_din || stk_din !== wv) din_bad = 1'b1;
            end
            if (stk_pop) begin
                n_pop++;
                if (pop_cyc == 0) pop_cyc = cyc;
            end
            if (done) begin
                got = 1'b1; g_res = result; g_err = err; g_dep = int'(depth);
            end
            prev_din = stk_din;
        end
        chk({tag, " done_cycle"}, 32'(cyc), 32'(lat));
        chk({tag, " err"}, 32'(g_err), 32'(m_err));
        chk({tag, " result"}, 32'(g_res), 32'(m_result));
        chk({tag, " depth"}, 32'(g_dep), 32'(mq.size()));
        chk({tag, " pushes"}, 32'(n_push), 32'(e_push));
        chk({tag, " pops"}, 32'(n_pop), 32'(e_pop));
        if (e_push > 0) begin
            chk({tag, " push_cycle"}, 32'(push_cyc), 32'(lat - 1));
            chk({tag, " din_stable"}, 32'(din_bad), 32'd0);
        end
        if (e_pop > 0) chk({tag, " pop_cycle"}, 32'(pop_cyc), 32'd3);
        chk({tag, " stack_size"}, 32'(sp), 32'(mq.size()));
        if (mq.size() > 0) chk({tag, " stack_top"}, 32'(stk_dout), 32'(mq[$]));
        @(negedge clk);
        chk({tag, " done_width"}, 32'(done), 32'd0);
        chk({tag, " ready_after"}, 32'(op_ready), 32'd1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] imm;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_dep;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [7:0] r;
        logic       e;
        int         dp;
        logic [7:0] last;
        int         cyc;
        int         n_done;

        rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_imm = 8'h00;
        m_result = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset op_ready", 32'(op_ready), 32'd1);
        chk("reset pulses", {28'd0, stk_push, stk_pop, done, err}, 32'd0);
        chk("reset stk_din", 32'(stk_din), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset depth", 32'(depth), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        vt[0]  = '{PUSH, 8'h05, 8'h05, 1'b0, 1};
        vt[1]  = '{POP,  8'h00, 8'h05, 1'b0, 0};
        vt[2]  = '{POP,  8'h00, 8'h05, 1'b1, 0};
        vt[3]  = '{PUSH, 8'h10, 8'h10, 1'b0, 1};
        vt[4]  = '{PUSH, 8'h03, 8'h03, 1'b0, 2};
        vt[5]  = '{SUB,  8'h00, 8'h0D, 1'b0, 1};
        vt[6]  = '{ADD,  8'h00, 8'h0D, 1'b1, 1};
        vt[7]  = '{POP,  8'h00, 8'h0D, 1'b0, 0};
        vt[8]  = '{PUSH, 8'hFF, 8'hFF, 1'b0, 1};
        vt[9]  = '{PUSH, 8'h02, 8'h02, 1'b0, 2};
        vt[10] = '{ADD,  8'h00, 8'h01, 1'b0, 1};
        vt[11] = '{NOT_, 8'h00, 8'hFE, 1'b0, 1};
        vt[12] = '{DUP,  8'h00, 8'hFE, 1'b0, 2};
        vt[13] = '{AND_, 8'h00, 8'hFE, 1'b0, 1};
        vt[14] = '{PUSH, 8'h0F, 8'h0F, 1'b0, 2};
        vt[15] = '{OR_,  8'h00, 8'hFF, 1'b0, 1};
        vt[16] = '{POP,  8'h00, 8'hFF, 1'b0, 0};

        for (int i = 0; i < 17; i++) begin
            run_op(vt[i].op, vt[i].imm, $sformatf("vec%0d", i), r, e, dp);
            chk($sformatf("vec%0d table_result", i), 32'(r), 32'(vt[i].exp_res));
            chk($sformatf("vec%0d table_err", i), 32'(e), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d table_depth", i), 32'(dp), 32'(vt[i].exp_dep));
        end

        // Full stack boundary.
        do_reset();
        last = 8'h00;
        for (int i = 0; i < 1023; i++) begin
            last = 8'($urandom);
            run_op(PUSH, last, "fill", r, e, dp);
        end
        chk("full depth", 32'(depth), 32'd1023);
        run_op(PUSH, 8'hAA, "full push", r, e, dp);
        chk("full push err", 32'(e), 32'd1);
        chk("full push depth", 32'(dp), 32'd1023);
        run_op(DUP, 8'h00, "full dup", r, e, dp);
        chk("full dup err", 32'(e), 32'd1);
        run_op(POP, 8'h00, "full pop", r, e, dp);
        chk("full pop result", 32'(r), 32'(last));
        chk("full pop depth", 32'(dp), 32'd1022);

        // op_valid held high while busy: second PUSH only accepted after returning to IDLE.
        do_reset();
        op_valid = 1'b1; op_code = PUSH; op_imm = 8'h33;
        @(posedge clk);
        n_done = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 4) chk($sformatf("hold ready c%0d", c), 32'(op_ready), 32'd0);
            if (c == 5) chk("hold ready c5", 32'(op_ready), 32'd1);
            if (done) begin
                n_done++;
                chk($sformatf("hold done_at c%0d", c), 32'((c == 4) || (c == 9)), 32'd1);
            end
        end
        op_valid = 1'b0;
        chk("hold done_count", 32'(n_done), 32'd2);
        chk("hold depth", 32'(depth), 32'd2);
        mq.push_back(8'h33); mq.push_back(8'h33); m_result = 8'h33;
        @(negedge clk);

        // Reset during POP_A of an ADD.
        do_reset();
        run_op(PUSH, 8'h01, "rst push1", r, e, dp);
        run_op(PUSH, 8'h02, "rst push2", r, e, dp);
        op_valid = 1'b1; op_code = ADD; op_imm = 8'h00;
        @(posedge clk);
        cyc = 0;
        while (!stk_pop && cyc < 10) begin @(negedge clk); cyc++; end
        chk("rst pop_a reached", 32'(cyc), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst async pulses", {28'd0, stk_push, stk_pop, done, err}, 32'd0);
        chk("rst async ready", 32'(op_ready), 32'd1);
        chk("rst async depth", 32'(depth), 32'd0);
        chk("rst async result", 32'(result), 32'd0);
        mq.delete(); m_result = 8'h00;
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_done += int'(stk_push) + int'(stk_pop) + int'(done);
        end
        chk("rst no_pulses", 32'(n_done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst release ready", 32'(op_ready), 32'd1);
        @(posedge clk);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            op_valid = 1'b0;
        end
        chk("rst post add cycle", 32'(cyc), 32'd2);
        chk("rst post add err", 32'(err), 32'd1);
        chk("rst post depth", 32'(depth), 32'd0);
        @(negedge clk);

        // Randomised ops against the reference model, biased toward pushes.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) < 4) ? PUSH : 3'($urandom_range(1, 7));
            run_op(op, 8'($urandom), $sformatf("rnd%0d", i), r, e, dp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
